// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - registered 1-to-4 valid/ready stream demux with broadcast
module demux_1to4_stream (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_dest,
  input  logic        in_bcast,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [31:0] out_data0,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic [15:0] accept_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e state_q [4];
  chan_state_e state_d [4];
  logic [31:0] data_q  [4];
  logic [31:0] data_d  [4];
  logic [15:0] count_q;
  logic [15:0] count_d;

  logic [3:0] free;
  logic [3:0] load;
  logic       accept;

  // Handshake: a channel is free when empty or draining this cycle; broadcast needs all four
  always_comb begin
    free = '0;
    for (int i = 0; i < 4; i++) begin
      free[i] = (state_q[i] == EMPTY) | out_ready[i];
    end
    if (reset) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &free;
    end else begin
      in_ready = free[in_dest];
    end
    accept = in_valid & in_ready;
  end

  // Next state per channel: load wins over drain so a drain+load keeps the channel full
  always_comb begin
    load = '0;
    for (int i = 0; i < 4; i++) begin
      load[i]    = accept & (in_bcast | (in_dest == 2'(i)));
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      case (state_q[i])
        EMPTY: begin
          if (load[i]) begin
            state_d[i] = FULL;
          end
        end
        FULL: begin
          if (out_ready[i] && !load[i]) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
      if (load[i]) begin
        data_d[i] = in_data;
      end
    end
    count_d = count_q + {15'd0, accept};
  end

  // State registers; reset discards held words and clears the accept counter
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= 32'h0;
      end
      count_q <= 16'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
      count_q <= count_d;
    end
  end

  // Registered outputs straight from channel state
  always_comb begin
    out_valid = '0;
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  assign out_data0    = data_q[0];
  assign out_data1    = data_q[1];
  assign out_data2    = data_q[2];
  assign out_data3    = data_q[3];
  assign accept_count = count_q;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb/tb_demux_1to4_stream.sv - self-checking bench for demux_1to4_stream
module tb_demux_1to4_stream;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_dest;
  logic        in_bcast;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [15:0] accept_count;

  logic [31:0] od [4];
  logic [31:0] mq [4][$];
  logic [31:0] last_d [4];
  logic [15:0] exp_count;
  int n_checks;
  int n_pass;

  demux_1to4_stream dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .accept_count(accept_count)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Global time bound so the run always terminates
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 32'h0;
    in_dest  = 2'd0;
    in_bcast = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    out_ready = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      last_d[i] = 32'h0;
    end
    exp_count = 16'h0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    in_valid = 1'b1; in_dest = 2'd1; in_bcast = 1'b0; in_data = 32'hAAAA5555;
    out_ready = 4'b1111;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else n_pass++;
    @(negedge clock);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready2: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 4'b0000) $display("FAIL reset_out_valid: got %b want 0000", out_valid); else n_pass++;
    n_checks++; if (accept_count !== 16'h0) $display("FAIL reset_count: got %h want 0000", accept_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (od[i] !== 32'h0) $display("FAIL reset_data%0d: got %h want 0", i, od[i]); else n_pass++;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_unicast();
    do_reset();
    @(negedge clock);
    out_ready = 4'b1111;
    in_valid = 1'b1; in_dest = 2'd2; in_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL uni_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b0100) $display("FAIL uni_out_valid: got %b want 0100", out_valid); else n_pass++;
    n_checks++; if (out_data2 !== 32'hDEADBEEF) $display("FAIL uni_data2: got %h want deadbeef", out_data2); else n_pass++;
    @(negedge clock);
    #1;
    n_checks++; if (out_valid !== 4'b0000) $display("FAIL uni_drained: got %b want 0000", out_valid); else n_pass++;
    n_checks++; if (accept_count !== 16'd1) $display("FAIL uni_count: got %0d want 1", accept_count); else n_pass++;
    n_checks++; if (out_data2 !== 32'hDEADBEEF) $display("FAIL uni_data_hold: got %h want deadbeef", out_data2); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clock);
    out_ready = 4'b1101;
    in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h0000_00A1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_first_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clock);
    in_data = 32'h0000_00B2;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_second_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 4'b0010) $display("FAIL stall_held: got %b want 0010", out_valid); else n_pass++;
    @(negedge clock);
    in_dest = 2'd3; in_data = 32'h0000_00C3;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_other_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clock);
    in_dest = 2'd1; in_data = 32'h0000_00B2;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_still_blocked: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 4'b1010) $display("FAIL stall_both_valid: got %b want 1010", out_valid); else n_pass++;
    n_checks++; if (out_data3 !== 32'h0000_00C3) $display("FAIL stall_data3: got %h want 000000c3", out_data3); else n_pass++;
    n_checks++; if (out_data1 !== 32'h0000_00A1) $display("FAIL stall_data1a: got %h want 000000a1", out_data1); else n_pass++;
    @(negedge clock);
    out_ready = 4'b1111;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b0010) $display("FAIL stall_second_valid: got %b want 0010", out_valid); else n_pass++;
    n_checks++; if (out_data1 !== 32'h0000_00B2) $display("FAIL stall_data1b: got %h want 000000b2", out_data1); else n_pass++;
    n_checks++; if (accept_count !== 16'd3) $display("FAIL stall_count: got %0d want 3", accept_count); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [8];
    do_reset();
    for (int k = 0; k < 8; k++) w[k] = $urandom;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      out_ready = 4'b1111;
      in_valid = 1'b1; in_dest = 2'd0; in_bcast = 1'b0; in_data = w[k];
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", k, in_ready); else n_pass++;
      if (k > 0) begin
        n_checks++; if (out_valid !== 4'b0001) $display("FAIL b2b_valid%0d: got %b want 0001", k, out_valid); else n_pass++;
        n_checks++; if (out_data0 !== w[k-1]) $display("FAIL b2b_data%0d: got %h want %h", k, out_data0, w[k-1]); else n_pass++;
      end
    end
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b0001) $display("FAIL b2b_last_valid: got %b want 0001", out_valid); else n_pass++;
    n_checks++; if (out_data0 !== w[7]) $display("FAIL b2b_last_data: got %h want %h", out_data0, w[7]); else n_pass++;
    n_checks++; if (accept_count !== 16'd8) $display("FAIL b2b_count: got %0d want 8", accept_count); else n_pass++;
    @(negedge clock);
    #1;
    n_checks++; if (out_valid !== 4'b0000) $display("FAIL b2b_drained: got %b want 0000", out_valid); else n_pass++;
  endtask

  task automatic test_broadcast();
    do_reset();
    @(negedge clock);
    out_ready = 4'b0111;
    in_valid = 1'b1; in_dest = 2'd3; in_data = 32'h0BAD_F00D;
    @(negedge clock);
    in_bcast = 1'b1; in_dest = 2'd0; in_data = 32'h12345678;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bc_blocked_ready%0d: got %b want 0", k, in_ready); else n_pass++;
      n_checks++; if (out_valid !== 4'b1000) $display("FAIL bc_no_partial%0d: got %b want 1000", k, out_valid); else n_pass++;
      n_checks++; if (out_data0 !== 32'h0) $display("FAIL bc_no_load%0d: got %h want 0", k, out_data0); else n_pass++;
      @(negedge clock);
    end
    out_ready = 4'b1111;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bc_release_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b1111) $display("FAIL bc_all_valid: got %b want 1111", out_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (od[i] !== 32'h12345678) $display("FAIL bc_data%0d: got %h want 12345678", i, od[i]); else n_pass++;
    end
    n_checks++; if (accept_count !== 16'd2) $display("FAIL bc_count: got %0d want 2", accept_count); else n_pass++;
  endtask

  task automatic test_random(input int n);
    logic [3:0] exp_free;
    logic [3:0] exp_valid;
    logic [31:0] exp_data;
    logic exp_rdy;
    do_reset();
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      in_valid = 1'($urandom_range(0, 1));
      in_dest  = 2'($urandom_range(0, 3));
      in_bcast = ($urandom_range(0, 5) == 0);
      in_data  = $urandom;
      for (int i = 0; i < 4; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_free[i]  = (mq[i].size() == 0) || out_ready[i];
        exp_valid[i] = (mq[i].size() != 0);
      end
      exp_rdy = in_bcast ? (exp_free == 4'b1111) : exp_free[in_dest];
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_ready c%0d: got %b want %b", k, in_ready, exp_rdy); else n_pass++;
      n_checks++; if (out_valid !== exp_valid) $display("FAIL rnd_valid c%0d: got %b want %b", k, out_valid, exp_valid); else n_pass++;
      for (int i = 0; i < 4; i++) begin
        exp_data = (mq[i].size() != 0) ? mq[i][0] : last_d[i];
        n_checks++; if (od[i] !== exp_data) $display("FAIL rnd_data%0d c%0d: got %h want %h", i, k, od[i], exp_data); else n_pass++;
      end
      n_checks++; if (accept_count !== exp_count) $display("FAIL rnd_count c%0d: got %0d want %0d", k, accept_count, exp_count); else n_pass++;
      for (int i = 0; i < 4; i++) begin
        if (mq[i].size() != 0 && out_ready[i]) void'(mq[i].pop_front());
      end
      if (in_valid && exp_rdy) begin
        exp_count = exp_count + 16'd1;
        for (int i = 0; i < 4; i++) begin
          if (in_bcast || in_dest == 2'(i)) begin
            mq[i].push_back(in_data);
            last_d[i] = in_data;
          end
        end
      end
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_wrap();
    logic [15:0] want [3];
    want[0] = 16'hFFFF; want[1] = 16'h0000; want[2] = 16'h0001;
    do_reset();
    @(negedge clock);
    out_ready = 4'b1111;
    in_valid = 1'b1; in_dest = 2'd0; in_bcast = 1'b0; in_data = 32'h5A5A5A5A;
    repeat (65534) @(negedge clock);
    #1;
    n_checks++; if (accept_count !== 16'hFFFE) $display("FAIL wrap_preload: got %h want fffe", accept_count); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      n_checks++; if (accept_count !== want[k]) $display("FAIL wrap_step%0d: got %h want %h", k, accept_count, want[k]); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clock);
    out_ready = 4'b0000;
    in_valid = 1'b1; in_dest = 2'd0; in_data = 32'h1111_0000;
    @(negedge clock);
    in_dest = 2'd2; in_data = 32'h2222_0002;
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b0101) $display("FAIL rmid_pre_valid: got %b want 0101", out_valid); else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    out_ready = 4'b1111;
    in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h3333_0001;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b want 0", in_ready); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b0000) $display("FAIL rmid_valid: got %b want 0000", out_valid); else n_pass++;
    n_checks++; if (out_data0 !== 32'h0) $display("FAIL rmid_data0: got %h want 0", out_data0); else n_pass++;
    n_checks++; if (out_data1 !== 32'h0) $display("FAIL rmid_data1: got %h want 0", out_data1); else n_pass++;
    n_checks++; if (out_data2 !== 32'h0) $display("FAIL rmid_data2: got %h want 0", out_data2); else n_pass++;
    n_checks++; if (accept_count !== 16'h0) $display("FAIL rmid_count: got %h want 0", accept_count); else n_pass++;
    @(negedge clock);
    in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h9999_0001;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rmid_post_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clock);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 4'b0010) $display("FAIL rmid_post_valid: got %b want 0010", out_valid); else n_pass++;
    n_checks++; if (out_data1 !== 32'h9999_0001) $display("FAIL rmid_post_data: got %h want 99990001", out_data1); else n_pass++;
    n_checks++; if (accept_count !== 16'd1) $display("FAIL rmid_post_count: got %0d want 1", accept_count); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    out_ready = 4'b0000;
    idle_inputs();
    exp_count = 16'h0;
    repeat (2) @(posedge clock);
    test_reset();
    test_unicast();
    test_stall();
    test_back_to_back();
    test_broadcast();
    test_random(400);
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
